mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single unified memory of the multicycle processor between the CPU datapath (instruction fetch and load/store via the IorD path) and an external loader/debug port. It serialises accesses, holds the memory port for a fixed latency and returns read data with a one-cycle done pulse. It raises a stall to the control unit while a CPU access is pending. It sits between DataPath/Controller and the memory model in the MIPS top level.

## Interface
- MEM_LATENCY, 2, number of cycles the memory port is held per access (must be ≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- Clk  in  1  sole clock, rising edge
- Rst  in  1  synchronous, active-high reset
- CpuReq / ExtReq  in  1  access request; held high until the matching Done
- CpuWe / ExtWe  in  1  1 = write, 0 = read
- CpuAddr / ExtAddr  in  ADDR_W  access address
- CpuWData / ExtWData  in  DATA_W  write data
- CpuRData / ExtRData  out  DATA_W  registered read data, valid from the Done cycle until the next completion for that requester
- CpuDone / ExtDone  out  1  one-cycle completion pulse
- Stall  out  1  CpuReq & ~CpuDone, combinational; freezes the Controller state
- MemEn  out  1  memory port active
- MemWe  out  1  write strobe
- MemAddr  out  ADDR_W  latched address
- MemWData  out  DATA_W  latched write data
- MemRData  in  DATA_W  memory read data, valid on the last ACCESS cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay.
  - If exactly one request, grant it.
  - If both request, grant the requester that is not LastGnt (round robin).
  - On grant: latch Owner, We, Addr and WData; load Cnt = MEM_LATENCY-1; go to ACCESS.
- ACCESS:
  - MemEn = 1 and Mem* driven from the latched registers.
  - MemWe = latched We, asserted only on the final ACCESS cycle (Cnt == 0), so a write commits exactly once.
  - If Cnt ≠ 0, decrement Cnt.
  - If Cnt == 0 and the access is a read, capture MemRData into the owner's RData register; go to RESP.
- RESP:
  - The owner's Done = 1 for exactly one cycle.
  - LastGnt ← Owner; go to IDLE.
- Request changes after grant (address, data, We, or dropping Req) are ignored; the latched access completes and Done still pulses.
- A request withdrawn before grant produces no access.
- A Req still high when the FSM is in IDLE is a new request; back-to-back requests from the same requester are legal.
- Cnt width is $clog2(MEM_LATENCY+1).
- Reset values:
  - state IDLE, Cnt 0, LastGnt = Ext (so the CPU wins the first tie).
  - MemEn, MemWe, CpuDone and ExtDone are 0.
  - MemAddr, MemWData, CpuRData and ExtRData are 0.

## Timing
- Req sampled high in IDLE at edge E0 → ACCESS occupies cycles E0..E(L) → Done is high during the cycle after E(L). L = MEM_LATENCY.
- Request-to-Done latency: L+1 edges. Minimum repeat interval per access: L+2 cycles.
- A requester must drop Req in the cycle it samples Done, or it issues a new access.
- Simultaneous CpuReq and ExtReq arriving while busy: both wait; on return to IDLE they alternate strictly.
- Rst asserted mid-ACCESS:
  - Next edge returns the FSM to IDLE with MemEn = 0.
  - An in-flight write whose final cycle has not been reached is never committed.
  - No Done is emitted for the aborted access.
- Stall has no registered delay. It drops in the same cycle CpuDone is high.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - owner encoding OWN_CPU = 1'b0, OWN_EXT = 1'b1
- Sub-module mem_arb_rr: a 2-way round-robin picker (inputs: two requests and LastGnt; outputs: grant valid and owner).
- Counter, latch registers and FSM stay in mem_arbiter.

## Test plan
- L=2, CpuReq read at address 0x40, memory returns 0x1234ABCD → MemEn high for 2 cycles, CpuDone one cycle later, CpuRData = 0x1234ABCD, Stall high from request until Done.
- CpuReq and ExtReq asserted in the same cycle, twice in a row → grant order CPU, Ext, CPU, Ext; no cycle has both Done signals high.
- ExtReq write 0xDEADBEEF to 0x100 → MemWe high only on the 2nd ACCESS cycle; a readback returns 0xDEADBEEF.
- CpuAddr changed from 0x40 to 0x80 one cycle after grant → MemAddr stays 0x40 throughout.
- Rst asserted on the 1st ACCESS cycle of a write → MemWe never high, no Done pulse, all outputs zero next cycle.
- MEM_LATENCY=1, CpuReq held high continuously → CpuDone pulses every 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared types for the unified-memory arbiter        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_if : CPU, loader and memory-port bundle              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              CpuReq;
  logic              CpuWe;
  logic [ADDR_W-1:0] CpuAddr;
  logic [DATA_W-1:0] CpuWData;
  logic [DATA_W-1:0] CpuRData;
  logic              CpuDone;
  logic              ExtReq;
  logic              ExtWe;
  logic [ADDR_W-1:0] ExtAddr;
  logic [DATA_W-1:0] ExtWData;
  logic [DATA_W-1:0] ExtRData;
  logic              ExtDone;
  logic              Stall;
  logic              MemEn;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;

  modport slave (
    input  CpuReq, CpuWe, CpuAddr, CpuWData,
    input  ExtReq, ExtWe, ExtAddr, ExtWData,
    input  MemRData,
    output CpuRData, CpuDone, ExtRData, ExtDone, Stall,
    output MemEn, MemWe, MemAddr, MemWData
  );

  modport master (
    output CpuReq, CpuWe, CpuAddr, CpuWData,
    output ExtReq, ExtWe, ExtAddr, ExtWData,
    output MemRData,
    input  CpuRData, CpuDone, ExtRData, ExtDone, Stall,
    input  MemEn, MemWe, MemAddr, MemWData
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_rr : 2-way round-robin picker                            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arb_rr (
  input  wire logic i_cpu_req,
  input  wire logic i_ext_req,
  input  wire logic i_last_gnt,
  output logic      o_gnt_valid,
  output logic      o_gnt_owner
);
  import mem_arb_pkg::*;

  assign o_gnt_valid = i_cpu_req | i_ext_req;
  // On a tie the side that did not win last time takes the port.
  assign o_gnt_owner = i_ext_req & (~i_cpu_req | (i_last_gnt == OWN_CPU));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : serialises CPU and loader accesses to one memory   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  wire logic    Clk,
  input  wire logic    Rst,
  mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  localparam int              CNT_W      = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MEM_LATENCY - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner;
  logic                r_we;
  logic                r_last_gnt;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_ext_rdata;
  logic                r_cpu_done;
  logic                r_ext_done;

  logic                w_gnt_valid;
  logic                w_gnt_owner;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  mem_arb_rr u_rr (
    .i_cpu_req   (bus.CpuReq),
    .i_ext_req   (bus.ExtReq),
    .i_last_gnt  (r_last_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_owner (w_gnt_owner)
  );

  assign w_sel_we    = (w_gnt_owner == OWN_EXT) ? bus.ExtWe    : bus.CpuWe;
  assign w_sel_addr  = (w_gnt_owner == OWN_EXT) ? bus.ExtAddr  : bus.CpuAddr;
  assign w_sel_wdata = (w_gnt_owner == OWN_EXT) ? bus.ExtWData : bus.CpuWData;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_last_gnt  <= OWN_EXT;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_ext_rdata <= '0;
      r_cpu_done  <= 1'b0;
      r_ext_done  <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_ext_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_owner  <= w_gnt_owner;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_cnt    <= c_cnt_load;
            r_mem_en <= 1'b1;
            r_mem_we <= w_sel_we && (c_cnt_load == '0);
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt    <= r_cnt - CNT_W'(1);
            // Write strobe only on the last held cycle so it commits once.
            r_mem_we <= r_we && (r_cnt == CNT_W'(1));
          end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (!r_we) begin
              if (r_owner == OWN_CPU) r_cpu_rdata <= bus.MemRData;
              else                    r_ext_rdata <= bus.MemRData;
            end
            r_cpu_done <= (r_owner == OWN_CPU);
            r_ext_done <= (r_owner == OWN_EXT);
            r_state    <= RESP;
          end
        end
        RESP: begin
          r_last_gnt <= r_owner;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.MemEn    = r_mem_en;
  assign bus.MemWe    = r_mem_we;
  assign bus.MemAddr  = r_addr;
  assign bus.MemWData = r_wdata;
  assign bus.CpuRData = r_cpu_rdata;
  assign bus.ExtRData = r_ext_rdata;
  assign bus.CpuDone  = r_cpu_done;
  assign bus.ExtDone  = r_ext_done;
  assign bus.Stall    = bus.CpuReq & ~r_cpu_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : directed bench, latency-2 and latency-1 arbiters|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

  mem_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) u_dut0 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (if0)
  );

  mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (if1)
  );

  // Word-addressed memory model behind the latency-2 arbiter, with a bench preload port.
  logic [31:0] mem [0:255];
  logic        pre_we   = 1'b0;
  logic [7:0]  pre_idx  = '0;
  logic [31:0] pre_data = '0;

  always @(posedge Clk) begin
    if (pre_we)                   mem[pre_idx] <= pre_data;
    else if (if0.MemEn && if0.MemWe) mem[if0.MemAddr[9:2]] <= if0.MemWData;
  end

  assign if0.MemRData = mem[if0.MemAddr[9:2]];
  assign if1.MemRData = 32'hCAFEF00D;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    step();
    pre_we = 1'b0;
  endtask

  task automatic idle_inputs();
    if0.CpuReq = 0; if0.CpuWe = 0; if0.CpuAddr = '0; if0.CpuWData = '0;
    if0.ExtReq = 0; if0.ExtWe = 0; if0.ExtAddr = '0; if0.ExtWData = '0;
    if1.CpuReq = 0; if1.CpuWe = 0; if1.CpuAddr = '0; if1.CpuWData = '0;
    if1.ExtReq = 0; if1.ExtWe = 0; if1.ExtAddr = '0; if1.ExtWData = '0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(); step();
    n_checks++; if (if0.MemEn !== 1'b0) $display("FAIL reset_memen: got %b exp 0", if0.MemEn); else n_pass++;
    n_checks++; if (if0.MemWe !== 1'b0) $display("FAIL reset_memwe: got %b exp 0", if0.MemWe); else n_pass++;
    n_checks++; if ({if0.CpuDone, if0.ExtDone} !== 2'b00) $display("FAIL reset_done: got %b exp 00", {if0.CpuDone, if0.ExtDone}); else n_pass++;
    n_checks++; if (if0.MemAddr !== 32'h0) $display("FAIL reset_memaddr: got %h exp 0", if0.MemAddr); else n_pass++;
    n_checks++; if (if0.MemWData !== 32'h0) $display("FAIL reset_memwdata: got %h exp 0", if0.MemWData); else n_pass++;
    n_checks++; if (if0.CpuRData !== 32'h0 || if0.ExtRData !== 32'h0) $display("FAIL reset_rdata: got %h/%h exp 0/0", if0.CpuRData, if0.ExtRData); else n_pass++;
    n_checks++; if (if0.Stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", if0.Stall); else n_pass++;
    Rst = 1'b0;
    step();
    n_checks++; if (if0.MemEn !== 1'b0) $display("FAIL idle_memen: got %b exp 0", if0.MemEn); else n_pass++;
  endtask

  task automatic test_cpu_read();
    if0.CpuReq = 1; if0.CpuWe = 0; if0.CpuAddr = 32'h40;
    #1;
    n_checks++; if (if0.Stall !== 1'b1) $display("FAIL read_stall_req: got %b exp 1", if0.Stall); else n_pass++;
    step();
    n_checks++; if (if0.MemEn !== 1'b1 || if0.MemWe !== 1'b0) $display("FAIL read_acc1: got en=%b we=%b exp en=1 we=0", if0.MemEn, if0.MemWe); else n_pass++;
    n_checks++; if (if0.MemAddr !== 32'h40) $display("FAIL read_addr: got %h exp 40", if0.MemAddr); else n_pass++;
    n_checks++; if (if0.Stall !== 1'b1 || if0.CpuDone !== 1'b0) $display("FAIL read_acc1_stall: got stall=%b done=%b exp 1/0", if0.Stall, if0.CpuDone); else n_pass++;
    step();
    n_checks++; if (if0.MemEn !== 1'b1 || if0.CpuDone !== 1'b0) $display("FAIL read_acc2: got en=%b done=%b exp 1/0", if0.MemEn, if0.CpuDone); else n_pass++;
    step();
    n_checks++; if (if0.MemEn !== 1'b0 || if0.CpuDone !== 1'b1) $display("FAIL read_done: got en=%b done=%b exp 0/1", if0.MemEn, if0.CpuDone); else n_pass++;
    n_checks++; if (if0.Stall !== 1'b0) $display("FAIL read_stall_done: got %b exp 0", if0.Stall); else n_pass++;
    n_checks++; if (if0.CpuRData !== 32'h1234ABCD) $display("FAIL read_data: got %h exp 1234abcd", if0.CpuRData); else n_pass++;
    if0.CpuReq = 0;
    step();
    n_checks++; if (if0.CpuDone !== 1'b0 || if0.CpuRData !== 32'h1234ABCD) $display("FAIL read_after: got done=%b data=%h exp 0/1234abcd", if0.CpuDone, if0.CpuRData); else n_pass++;
    step();
  endtask

  task automatic test_round_robin();
    int order [4];
    int nd   = 0;
    int both = 0;
    Rst = 1'b1; step(); step(); Rst = 1'b0;
    if0.CpuReq = 1; if0.CpuWe = 0; if0.CpuAddr = 32'h0;
    if0.ExtReq = 1; if0.ExtWe = 0; if0.ExtAddr = 32'h4;
    for (int k = 0; k < 40 && nd < 4; k++) begin
      step();
      if (if0.CpuDone && if0.ExtDone) both++;
      if (if0.CpuDone) begin order[nd] = 0; nd++; end
      else if (if0.ExtDone) begin order[nd] = 1; nd++; end
      if (nd == 4) begin if0.CpuReq = 0; if0.ExtReq = 0; end
    end
    if0.CpuReq = 0; if0.ExtReq = 0;
    n_checks++; if (nd !== 4) $display("FAIL rr_count: got %0d dones exp 4", nd);
    else begin
      n_pass++;
      n_checks++; if ({order[0][0], order[1][0], order[2][0], order[3][0]} !== 4'b0101)
        $display("FAIL rr_order: got %0d%0d%0d%0d exp 0101 (0=cpu)", order[0], order[1], order[2], order[3]); else n_pass++;
    end
    n_checks++; if (both !== 0) $display("FAIL rr_both_done: got %0d exp 0", both); else n_pass++;
    n_checks++; if (if0.CpuRData !== 32'h11110000 || if0.ExtRData !== 32'h22220001) $display("FAIL rr_data: got %h/%h exp 11110000/22220001", if0.CpuRData, if0.ExtRData); else n_pass++;
    step(); step();
  endtask

  task automatic test_ext_write();
    bit got = 0;
    if0.ExtReq = 1; if0.ExtWe = 1; if0.ExtAddr = 32'h100; if0.ExtWData = 32'hDEADBEEF;
    step();
    n_checks++; if (if0.MemEn !== 1'b1 || if0.MemWe !== 1'b0 || if0.MemAddr !== 32'h100) $display("FAIL wr_acc1: got en=%b we=%b addr=%h exp 1/0/100", if0.MemEn, if0.MemWe, if0.MemAddr); else n_pass++;
    step();
    n_checks++; if (if0.MemEn !== 1'b1 || if0.MemWe !== 1'b1 || if0.MemWData !== 32'hDEADBEEF) $display("FAIL wr_acc2: got en=%b we=%b wd=%h exp 1/1/deadbeef", if0.MemEn, if0.MemWe, if0.MemWData); else n_pass++;
    step();
    n_checks++; if (if0.MemWe !== 1'b0 || if0.ExtDone !== 1'b1) $display("FAIL wr_done: got we=%b done=%b exp 0/1", if0.MemWe, if0.ExtDone); else n_pass++;
    if0.ExtReq = 0; if0.ExtWe = 0;
    step();
    if0.CpuReq = 1; if0.CpuWe = 0; if0.CpuAddr = 32'h100;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (if0.CpuDone) got = 1;
    end
    if0.CpuReq = 0;
    n_checks++; if (got !== 1'b1) $display("FAIL wr_readback_timeout: got no done exp done"); else n_pass++;
    n_checks++; if (if0.CpuRData !== 32'hDEADBEEF) $display("FAIL wr_readback: got %h exp deadbeef", if0.CpuRData); else n_pass++;
    step(); step();
  endtask

  task automatic test_addr_change();
    bit got = 0;
    if0.CpuReq = 1; if0.CpuWe = 0; if0.CpuAddr = 32'h40;
    step();
    if0.CpuAddr = 32'h80; if0.CpuWe = 1; if0.CpuWData = 32'hFFFFFFFF;
    n_checks++; if (if0.MemAddr !== 32'h40) $display("FAIL chg_addr1: got %h exp 40", if0.MemAddr); else n_pass++;
    step();
    n_checks++; if (if0.MemAddr !== 32'h40 || if0.MemWe !== 1'b0) $display("FAIL chg_addr2: got addr=%h we=%b exp 40/0", if0.MemAddr, if0.MemWe); else n_pass++;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (if0.CpuDone) got = 1;
    end
    if0.CpuReq = 0; if0.CpuWe = 0;
    n_checks++; if (got !== 1'b1 || if0.CpuRData !== 32'h1234ABCD) $display("FAIL chg_data: got done=%b data=%h exp 1/1234abcd", got, if0.CpuRData); else n_pass++;
    step(); step();
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    if0.ExtReq = 1; if0.ExtWe = 1; if0.ExtAddr = 32'h200; if0.ExtWData = 32'h55AA55AA;
    step();
    n_checks++; if (if0.MemEn !== 1'b1 || if0.MemWe !== 1'b0) $display("FAIL abort_acc1: got en=%b we=%b exp 1/0", if0.MemEn, if0.MemWe); else n_pass++;
    Rst = 1'b1; if0.ExtReq = 0; if0.ExtWe = 0;
    step();
    n_checks++; if ({if0.MemEn, if0.MemWe, if0.CpuDone, if0.ExtDone} !== 4'b0000) $display("FAIL abort_ctrl: got %b exp 0000", {if0.MemEn, if0.MemWe, if0.CpuDone, if0.ExtDone}); else n_pass++;
    n_checks++; if (if0.MemAddr !== 32'h0 || if0.MemWData !== 32'h0) $display("FAIL abort_bus: got %h/%h exp 0/0", if0.MemAddr, if0.MemWData); else n_pass++;
    n_checks++; if (if0.CpuRData !== 32'h0 || if0.ExtRData !== 32'h0) $display("FAIL abort_rdata: got %h/%h exp 0/0", if0.CpuRData, if0.ExtRData); else n_pass++;
    Rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (if0.MemEn || if0.MemWe || if0.CpuDone || if0.ExtDone) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL abort_quiet: got %0d active cycles exp 0", bad); else n_pass++;
    n_checks++; if (mem[128] !== 32'h0) $display("FAIL abort_commit: got %h exp 0", mem[128]); else n_pass++;
  endtask

  task automatic test_latency1();
    if1.CpuReq = 1; if1.CpuWe = 0; if1.CpuAddr = 32'h8;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_checks++; if (if1.CpuDone !== ((k % 3) == 2)) $display("FAIL l1_done_%0d: got %b exp %b", k, if1.CpuDone, ((k % 3) == 2)); else n_pass++;
      if (k == 2) begin
        n_checks++; if (if1.CpuRData !== 32'hCAFEF00D || if1.Stall !== 1'b0) $display("FAIL l1_data: got %h stall=%b exp cafef00d/0", if1.CpuRData, if1.Stall); else n_pass++;
      end
    end
    if1.CpuReq = 0;
    step(); step(); step();
  endtask

  initial begin
    idle_inputs();
    Rst = 1'b1;
    step();
    preload(8'h10, 32'h1234ABCD);
    preload(8'h00, 32'h11110000);
    preload(8'h01, 32'h22220001);
    preload(8'h40, 32'h00000000);
    preload(8'h80, 32'h00000000);
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_ext_write();
    test_addr_change();
    test_reset_abort();
    test_latency1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
